ram_sync: RTL and testbench

RAM_SYNC -- requirements
Module: ram_sync

---
 rtl/ram_sync.sv | 101 ++++++++++
 tb/tb_ram_sync.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_sync.sv
// Single-port synchronous RAM with registered read-first output and an
// optional post-reset zero-fill sequence that holds off user accesses.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_CLEAR | zero-fill in progress, one word per cycle, busy=1
// ST_IDLE  | normal operation, user reads/writes accepted, busy=0
module ram_sync #(
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] dout,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  re,
  input  logic                  we,
  output logic                  busy
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [ADDR_WIDTH-1:0]   r_clr_cnt;
  logic [ADDR_WIDTH-1:0]   w_clr_cnt_nxt;
  logic [DATA_WIDTH-1:0]   r_dout;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH];

  logic                    w_busy;
  logic                    w_mem_we;
  logic                    w_rd_en;
  logic [ADDR_WIDTH-1:0]   w_mem_addr;
  logic [DATA_WIDTH-1:0]   w_mem_din;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_clr_cnt <= w_clr_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_clr_cnt_nxt = r_clr_cnt;
    case (r_state)
      ST_CLEAR: begin
        w_clr_cnt_nxt = r_clr_cnt + 1'b1;
        if (r_clr_cnt == LAST_ADDR) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        w_clr_cnt_nxt = '0;
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_clr_cnt_nxt = '0;
      end
    endcase
  end

  assign w_busy = (r_state == ST_CLEAR);

  // One physical port: the clear sequence owns it while busy.
  // Gating with rst_n drops a write coinciding with reset assertion.
  assign w_mem_addr = w_busy ? r_clr_cnt : addr;
  assign w_mem_din  = w_busy ? '0 : din;
  assign w_mem_we   = rst_n & (w_busy | we);
  assign w_rd_en    = ~w_busy & re;

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_din;
    end
  end

  // Nonblocking read of the old word gives read-first behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dout <= '0;
    end else if (w_rd_en) begin
      r_dout <= r_mem[w_mem_addr];
    end
  end

  assign dout = r_dout;
  assign busy = w_busy;

endmodule

// File: tb/tb_ram_sync.sv
// Self-checking bench for ram_sync: a 12-bit instance for data-path scenarios,
// a 4-bit instance for clear/reset timing, and a 4-bit instance without clear.
module tb_ram_sync;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance A: default geometry, clear enabled
  logic        rst_n_a = 1'b1;
  logic [11:0] addr_a  = '0;
  logic [7:0]  din_a   = '0;
  logic        re_a    = 1'b0;
  logic        we_a    = 1'b0;
  logic [7:0]  dout_a;
  logic        busy_a;

  // Instance B: 16 words, clear enabled
  logic        rst_n_b = 1'b1;
  logic [3:0]  addr_b  = '0;
  logic [7:0]  din_b   = '0;
  logic        re_b    = 1'b0;
  logic        we_b    = 1'b0;
  logic [7:0]  dout_b;
  logic        busy_b;

  // Instance C: 16 words, clear disabled
  logic        rst_n_c = 1'b1;
  logic [3:0]  addr_c  = '0;
  logic [7:0]  din_c   = '0;
  logic        re_c    = 1'b0;
  logic        we_c    = 1'b0;
  logic [7:0]  dout_c;
  logic        busy_c;

  ram_sync u_dut_a (
    .clk(clk), .rst_n(rst_n_a), .addr(addr_a), .dout(dout_a),
    .din(din_a), .re(re_a), .we(we_a), .busy(busy_a)
  );

  ram_sync #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .CLEAR_ON_RESET(1'b1)) u_dut_b (
    .clk(clk), .rst_n(rst_n_b), .addr(addr_b), .dout(dout_b),
    .din(din_b), .re(re_b), .we(we_b), .busy(busy_b)
  );

  ram_sync #(.ADDR_WIDTH(4), .DATA_WIDTH(8), .CLEAR_ON_RESET(1'b0)) u_dut_c (
    .clk(clk), .rst_n(rst_n_c), .addr(addr_c), .dout(dout_c),
    .din(din_c), .re(re_c), .we(we_c), .busy(busy_c)
  );

  logic [7:0] model_a [4096];
  logic [7:0] model_b [16];
  logic [7:0] q_a [$];
  logic [7:0] q_b [$];

  // Drive one access at posedge+1, compare any read result one edge later.
  task automatic op_a(input logic r, input logic w, input logic [11:0] a,
                      input logic [7:0] d);
    logic [7:0] exp;
    re_a = r; we_a = w; addr_a = a; din_a = d;
    if (r) q_a.push_back(model_a[a]);
    if (w) model_a[a] = d;
    @(posedge clk); #1;
    re_a = 1'b0; we_a = 1'b0;
    if (r) begin
      exp = q_a.pop_front();
      checks++;
      if (dout_a !== exp) begin
        errors++;
        $display("FAIL read_a addr=%03h got=%02h exp=%02h", a, dout_a, exp);
      end
    end
  endtask

  task automatic op_b(input logic r, input logic w, input logic [3:0] a,
                      input logic [7:0] d);
    logic [7:0] exp;
    re_b = r; we_b = w; addr_b = a; din_b = d;
    if (r) q_b.push_back(model_b[a]);
    if (w) model_b[a] = d;
    @(posedge clk); #1;
    re_b = 1'b0; we_b = 1'b0;
    if (r) begin
      exp = q_b.pop_front();
      checks++;
      if (dout_b !== exp) begin
        errors++;
        $display("FAIL read_b addr=%0h got=%02h exp=%02h", a, dout_b, exp);
      end
    end
  endtask

  task automatic count_busy_b(input string name);
    int n = 0;
    while (busy_b === 1'b1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != 16 || busy_b !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_cycles got=%0d exp=16 busy=%b", name, n, busy_b);
    end
  endtask

  task automatic test_reset;
    checks++;
    if (dout_a !== 8'h00 || busy_a !== 1'b1) begin
      errors++;
      $display("FAIL reset_a dout=%02h busy=%b exp dout=00 busy=1", dout_a, busy_a);
    end
    checks++;
    if (dout_b !== 8'h00 || busy_b !== 1'b1) begin
      errors++;
      $display("FAIL reset_b dout=%02h busy=%b exp dout=00 busy=1", dout_b, busy_b);
    end
    checks++;
    if (dout_c !== 8'h00 || busy_c !== 1'b0) begin
      errors++;
      $display("FAIL reset_c dout=%02h busy=%b exp dout=00 busy=0", dout_c, busy_c);
    end
  endtask

  // Clear on A with a user write/read of address 0 held during the clear.
  task automatic test_clear_with_access;
    int n = 0;
    rst_n_a = 1'b1;
    re_a = 1'b1; we_a = 1'b1; addr_a = 12'h000; din_a = 8'hFF;
    while (busy_a === 1'b1 && n < 5000) begin
      @(posedge clk); #1;
      n++;
      if (n == 6) begin
        re_a = 1'b0; we_a = 1'b0;
        checks++;
        if (dout_a !== 8'h00) begin
          errors++;
          $display("FAIL dout_during_clear got=%02h exp=00", dout_a);
        end
      end
    end
    checks++;
    if (n != 4096 || busy_a !== 1'b0) begin
      errors++;
      $display("FAIL clear_a busy_cycles got=%0d exp=4096 busy=%b", n, busy_a);
    end
    for (int i = 0; i < 4096; i++) model_a[i] = 8'h00;
    op_a(1'b1, 1'b0, 12'h000, 8'h00);
    op_a(1'b1, 1'b0, 12'h001, 8'h00);
    op_a(1'b1, 1'b0, 12'hFFF, 8'h00);
    op_a(1'b1, 1'b0, 12'h800, 8'h00);
  endtask

  task automatic test_write_read;
    op_a(1'b0, 1'b1, 12'h123, 8'hA5);
    op_a(1'b1, 1'b0, 12'h123, 8'h00);
    op_a(1'b1, 1'b0, 12'h122, 8'h00);
    op_a(1'b1, 1'b0, 12'h124, 8'h00);
    op_a(1'b0, 1'b1, 12'hFFF, 8'hC3);
    op_a(1'b1, 1'b0, 12'hFFF, 8'h00);
  endtask

  task automatic test_read_first;
    op_a(1'b0, 1'b1, 12'h010, 8'h11);
    op_a(1'b1, 1'b1, 12'h010, 8'h22);
    op_a(1'b1, 1'b0, 12'h010, 8'h00);
  endtask

  task automatic test_hold;
    op_a(1'b0, 1'b1, 12'h200, 8'h5A);
    op_a(1'b0, 1'b1, 12'h201, 8'h77);
    op_a(1'b1, 1'b0, 12'h200, 8'h00);
    for (int i = 0; i < 5; i++) begin
      op_a(1'b0, 1'b0, 12'h201 + 12'(i), 8'h00);
      checks++;
      if (dout_a !== 8'h5A) begin
        errors++;
        $display("FAIL hold cycle=%0d got=%02h exp=5a", i, dout_a);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [11:0] a;
    for (int i = 0; i < 40; i++) begin
      a = 12'($urandom_range(0, 31)) | 12'h400;
      op_a(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a,
           8'($urandom_range(0, 255)));
    end
    for (int i = 0; i < 32; i++) op_a(1'b1, 1'b0, 12'h400 + 12'(i), 8'h00);
  endtask

  task automatic test_clear_small;
    rst_n_b = 1'b1;
    count_busy_b("clear_b");
    for (int i = 0; i < 16; i++) model_b[i] = 8'h00;
    for (int i = 0; i < 16; i++) op_b(1'b1, 1'b0, 4'(i), 8'h00);
  endtask

  task automatic test_reset_mid_access;
    op_b(1'b0, 1'b1, 4'h5, 8'h3C);
    op_b(1'b1, 1'b0, 4'h5, 8'h00);
    rst_n_b = 1'b0;
    #1;
    checks++;
    if (dout_b !== 8'h00 || busy_b !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_access dout=%02h busy=%b exp dout=00 busy=1", dout_b, busy_b);
    end
  endtask

  task automatic test_reset_mid_clear;
    @(posedge clk); #1;
    rst_n_b = 1'b1;
    repeat (7) @(posedge clk);
    #1;
    rst_n_b = 1'b0;
    #1;
    checks++;
    if (dout_b !== 8'h00 || busy_b !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_clear dout=%02h busy=%b exp dout=00 busy=1", dout_b, busy_b);
    end
    @(posedge clk); #1;
    rst_n_b = 1'b1;
    count_busy_b("restart_clear_b");
    for (int i = 0; i < 16; i++) model_b[i] = 8'h00;
    op_b(1'b1, 1'b0, 4'h5, 8'h00);
    op_b(1'b1, 1'b0, 4'hF, 8'h00);
  endtask

  task automatic test_no_clear;
    rst_n_c = 1'b1;
    #1;
    addr_c = 4'h3; din_c = 8'h5E; we_c = 1'b1;
    @(posedge clk); #1;
    we_c = 1'b0; re_c = 1'b1;
    @(posedge clk); #1;
    re_c = 1'b0;
    checks++;
    if (dout_c !== 8'h5E || busy_c !== 1'b0) begin
      errors++;
      $display("FAIL no_clear dout=%02h busy=%b exp dout=5e busy=0", dout_c, busy_c);
    end
  endtask

  initial begin
    #3;
    rst_n_a = 1'b0; rst_n_b = 1'b0; rst_n_c = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_clear_with_access();
    test_write_read();
    test_read_first();
    test_hold();
    test_back_to_back();
    test_clear_small();
    test_reset_mid_access();
    test_reset_mid_clear();
    test_no_clear();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
